packet_assembler: RTL and testbench

//   Ingress stage directly upstream of packet_parser. Collects an 8-bit byte

---
 rtl/packet_assembler.sv | 135 +++++++++++++
 tb/tb_packet_assembler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler.sv
// Byte-stream ingress for packet_parser: gathers valid/ready/last beats into a
// flat frame buffer, drops runt/oversize frames, and holds the buffer after each emit.
module packet_assembler #(
    parameter int unsigned MAX_BYTES  = 1518,
    parameter int unsigned MIN_BYTES  = 14,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [8*MAX_BYTES-1:0] packet_out_flat,
    output logic                   valid_out,
    output logic [10:0]            pkt_len,
    output logic [CNT_W-1:0]       frames_ok,
    output logic [CNT_W-1:0]       frames_dropped
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DROP,
        EMIT,
        GAP
    } state_t;

    state_t           state;
    logic [10:0]      cnt;
    logic [10:0]      cnt_inc;
    logic [GAP_W-1:0] gap_cnt;
    logic             beat;

    // Ready is forced low combinationally while reset is held.
    assign s_ready = rst && (state == IDLE || state == FILL || state == DROP);

    always_comb begin
        beat    = s_valid && s_ready;
        cnt_inc = cnt + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            gap_cnt         <= '0;
            packet_out_flat <= '0;
            valid_out       <= 1'b0;
            pkt_len         <= '0;
            frames_ok       <= '0;
            frames_dropped  <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        packet_out_flat <= {{(8*MAX_BYTES-8){1'b0}}, s_data};
                        cnt             <= 11'd1;
                        if (s_last) begin
                            if (MIN_BYTES > 1) begin
                                state <= IDLE;
                                if (frames_dropped != '1)
                                    frames_dropped <= frames_dropped + CNT_W'(1);
                            end else begin
                                pkt_len   <= 11'd1;
                                valid_out <= 1'b1;
                                state     <= EMIT;
                                if (frames_ok != '1)
                                    frames_ok <= frames_ok + CNT_W'(1);
                            end
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (beat) begin
                        if (cnt < 11'(MAX_BYTES)) begin
                            packet_out_flat[8*cnt +: 8] <= s_data;
                            cnt                         <= cnt_inc;
                            if (s_last) begin
                                if (cnt_inc >= 11'(MIN_BYTES)) begin
                                    pkt_len   <= cnt_inc;
                                    valid_out <= 1'b1;
                                    state     <= EMIT;
                                    if (frames_ok != '1)
                                        frames_ok <= frames_ok + CNT_W'(1);
                                end else begin
                                    state <= IDLE;
                                    if (frames_dropped != '1)
                                        frames_dropped <= frames_dropped + CNT_W'(1);
                                end
                            end
                        end else if (s_last) begin
                            state <= IDLE;
                            if (frames_dropped != '1)
                                frames_dropped <= frames_dropped + CNT_W'(1);
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                DROP: begin
                    if (beat && s_last) begin
                        state <= IDLE;
                        if (frames_dropped != '1)
                            frames_dropped <= frames_dropped + CNT_W'(1);
                    end
                end

                EMIT: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end

                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: frame sizes at the runt/max boundaries,
// back-to-back gap timing, bubbles and mid-frame reset.
module tb_packet_assembler;

    localparam int MAXB = 1518;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [8*MAXB-1:0] packet_out_flat;
    logic              valid_out;
    logic [10:0]       pkt_len;
    logic [CW-1:0]     frames_ok;
    logic [CW-1:0]     frames_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    int                vo_cnt    = 0;
    int                vo_double = 0;
    logic              vo_prev   = 1'b0;
    logic [10:0]       cap_len   = '0;
    logic [8*MAXB-1:0] cap_buf   = '0;

    packet_assembler #(
        .MAX_BYTES (MAXB),
        .MIN_BYTES (14),
        .GAP_CYCLES(4),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .packet_out_flat(packet_out_flat),
        .valid_out      (valid_out),
        .pkt_len        (pkt_len),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    // Snapshot each emitted frame; the next frame may overwrite the live buffer.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (vo_prev) vo_double++;
            vo_cnt++;
            cap_len = pkt_len;
            cap_buf = packet_out_flat;
        end
        vo_prev = (valid_out === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int id, input int i);
        if (id == 0) begin
            if (i == 12) return 8'h08;
            if (i == 13) return 8'h00;
            if (i == 23) return 8'h06;
            return 8'hAA;
        end
        return 8'((i * id) + (id * 13) + (i >> 8));
    endfunction

    function automatic int buf_errs(input logic [8*MAXB-1:0] b, input int id, input int wlen);
        int errs = 0;
        for (int i = 0; i < MAXB; i++) begin
            logic [7:0] e;
            e = (i < wlen) ? gen(id, i) : 8'h00;
            if (b[8*i +: 8] !== e) errs++;
        end
        return errs;
    endfunction

    function automatic int nonzero_bytes(input logic [8*MAXB-1:0] b);
        int n = 0;
        for (int i = 0; i < MAXB; i++)
            if (b[8*i +: 8] !== 8'h00) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves s_valid high after the last beat so the caller can chain frames.
    task automatic send(input int id, input int n, input bit bub, input int abort_at,
                        output int stalls);
        int   i     = 0;
        int   guard = 0;
        logic acc;
        stalls = 0;
        while (i < n && i != abort_at) begin
            if (bub && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = gen(id, i);
                s_last  = (i == n - 1);
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            if (s_valid && !s_ready) stalls++;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
            if (guard > 20000) begin
                check("send_timeout", 64'(i), 64'(n));
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ready"}, s_ready, 1'b0);
        check({tag, "_vo"}, valid_out, 1'b0);
        check({tag, "_len"}, pkt_len, 11'd0);
        check({tag, "_ok"}, frames_ok, 16'd0);
        check({tag, "_drop"}, frames_dropped, 16'd0);
        check({tag, "_buf"}, nonzero_bytes(packet_out_flat), 0);
    endtask

    initial begin
        int st;
        int vo_base;

        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_idle", s_ready, 1'b1);

        // 60-byte frame with EtherType/protocol bytes
        send(0, 60, 1'b0, -1, st);
        check("t1_latency", valid_out, 1'b1);
        check("t1_stall", st, 0);
        idle(8);
        check("t1_pulses", vo_cnt, 1);
        check("t1_len", cap_len, 11'd60);
        check("t1_type", cap_buf[96 +: 16], 16'h0008);
        check("t1_buf", buf_errs(cap_buf, 0, 60), 0);
        check("t1_ok", frames_ok, 16'd1);

        // runt, then minimum-length frame
        send(1, 13, 1'b0, -1, st);
        idle(8);
        check("t2_runt_pulses", vo_cnt, 1);
        check("t2_runt_drop", frames_dropped, 16'd1);
        check("t2_runt_len", pkt_len, 11'd60);
        send(2, 14, 1'b0, -1, st);
        idle(8);
        check("t2_min_pulses", vo_cnt, 2);
        check("t2_min_len", cap_len, 11'd14);
        check("t2_min_buf", buf_errs(cap_buf, 2, 14), 0);
        check("t2_ok", frames_ok, 16'd2);

        // maximum frame, then oversize
        send(3, 1518, 1'b0, -1, st);
        idle(8);
        check("t3_max_pulses", vo_cnt, 3);
        check("t3_max_len", cap_len, 11'd1518);
        check("t3_max_buf", buf_errs(cap_buf, 3, 1518), 0);
        send(4, 1600, 1'b0, -1, st);
        check("t3_over_stall", st, 0);
        idle(8);
        check("t3_over_pulses", vo_cnt, 3);
        check("t3_over_drop", frames_dropped, 16'd2);
        check("t3_over_len", pkt_len, 11'd1518);
        check("t3_over_buf", buf_errs(packet_out_flat, 4, 1518), 0);
        check("t3_ok", frames_ok, 16'd3);

        // back-to-back with s_valid held high
        send(5, 20, 1'b0, -1, st);
        check("t4_a_stall", st, 0);
        send(6, 31, 1'b0, -1, st);
        check("t4_b_stall", st, 5);
        check("t4_a_len", cap_len, 11'd20);
        check("t4_a_buf", buf_errs(cap_buf, 5, 20), 0);
        send(7, 14, 1'b0, -1, st);
        check("t4_c_stall", st, 5);
        check("t4_b_len", cap_len, 11'd31);
        check("t4_b_buf", buf_errs(cap_buf, 6, 31), 0);
        idle(8);
        check("t4_c_len", cap_len, 11'd14);
        check("t4_c_buf", buf_errs(cap_buf, 7, 14), 0);
        send(6, 31, 1'b1, -1, st);
        idle(8);
        check("t4_bub_len", cap_len, 11'd31);
        check("t4_bub_buf", buf_errs(cap_buf, 6, 31), 0);
        check("t4_pulses", vo_cnt, 7);
        check("t4_ok", frames_ok, 16'd7);

        // reset in the middle of a frame
        send(8, 40, 1'b0, 30, st);
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("t5");
        rst = 1'b1;
        vo_base = vo_cnt;
        idle(2);
        send(9, 64, 1'b0, -1, st);
        idle(8);
        check("t5_pulses", vo_cnt - vo_base, 1);
        check("t5_len", cap_len, 11'd64);
        check("t5_buf", buf_errs(cap_buf, 9, 64), 0);
        check("t5_ok", frames_ok, 16'd1);
        check("t5_drop", frames_dropped, 16'd0);

        check("vo_width", vo_double, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
